// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned AW_DEF = 12;
    localparam int unsigned DW_DEF = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned RUN_W  = 4;

    // Which access was issued in the previous cycle; drives the response side.
    typedef enum logic [1:0] {
        OpNone,
        OpFetch,
        OpLoad,
        OpStore
    } last_op_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the memory bus, bundled between pipeline/memory and arbiter.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);

    // Fetch port (P1)
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;

    // Load/store port (P4)
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_done;
    logic [DW-1:0] d_rdata;

    // Single-port synchronous memory
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_rw;
    logic [DW-1:0] m_q;

    // Arbiter side
    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_done, d_rdata,
        output m_addr, m_data, m_rw,
        input  m_q
    );

    // Pipeline and memory side
    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_done, d_rdata,
        input  m_addr, m_data, m_rw,
        output m_q
    );

endinterface

// File: rtl/mem_arb_sel.sv
// Combinational grant selection between fetch and data requesters.
// Purely a function of its inputs so it can be checked exhaustively in isolation.
module mem_arb_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned ADDR_LIMIT   = 4095
) (
    input  logic             f_req,
    input  logic [AW-1:0]    f_addr,
    input  logic             d_req,
    input  logic [AW-1:0]    d_addr,
    input  logic [RUN_W-1:0] run_cnt,
    output logic             f_issue,
    output logic             f_drop,
    output logic             d_issue,
    output logic             d_drop
);

    logic f_in_range;
    logic d_in_range;
    logic run_ok;

    // Data wins unless it has already starved a waiting fetch for MAX_DATA_RUN grants.
    // Out-of-range requests never reach memory; they are only acknowledged (dropped).
    always_comb begin
        f_in_range = 32'(f_addr) <= ADDR_LIMIT;
        d_in_range = 32'(d_addr) <= ADDR_LIMIT;
        run_ok     = (32'(run_cnt) < MAX_DATA_RUN) || !f_req;

        d_issue = d_req && d_in_range && run_ok;
        d_drop  = d_req && !d_in_range;
        f_issue = f_req && f_in_range && !d_issue;
        f_drop  = f_req && !f_in_range && !d_issue;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one synchronous memory port,
// returns read data one cycle after issue and raises a pipeline stall.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned ADDR_LIMIT   = 4095
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
    output logic              stall,
    output logic              err,
    output logic [CNT_W-1:0]  cnt_fetch,
    output logic [CNT_W-1:0]  cnt_data,
    output logic [CNT_W-1:0]  cnt_conflict
);

    last_op_e         last_op_q, last_op_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             err_q, err_d;
    logic [AW-1:0]    m_addr_q, m_addr_d;
    logic [DW-1:0]    f_rdata_q, f_rdata_d;
    logic [DW-1:0]    d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0] cnt_fetch_q, cnt_fetch_d;
    logic [CNT_W-1:0] cnt_data_q, cnt_data_d;
    logic [CNT_W-1:0] cnt_conflict_q, cnt_conflict_d;

    logic f_issue_raw, f_drop_raw, d_issue_raw, d_drop_raw;
    logic f_issue, f_drop, d_issue, d_drop;

    mem_arb_sel #(
        .AW           (AW),
        .MAX_DATA_RUN (MAX_DATA_RUN),
        .ADDR_LIMIT   (ADDR_LIMIT)
    ) u_sel (
        .f_req   (bus.f_req),
        .f_addr  (bus.f_addr),
        .d_req   (bus.d_req),
        .d_addr  (bus.d_addr),
        .run_cnt (run_cnt_q),
        .f_issue (f_issue_raw),
        .f_drop  (f_drop_raw),
        .d_issue (d_issue_raw),
        .d_drop  (d_drop_raw)
    );

    // No grant of any kind may escape while reset is held.
    always_comb begin
        f_issue = reset_n && f_issue_raw;
        f_drop  = reset_n && f_drop_raw;
        d_issue = reset_n && d_issue_raw;
        d_drop  = reset_n && d_drop_raw;
    end

    // State register: last issued operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_op_q <= OpNone;
        end else begin
            last_op_q <= last_op_d;
        end
    end

    // Next state: record what goes to memory this cycle.
    always_comb begin
        last_op_d = OpNone;
        if (d_issue) begin
            last_op_d = bus.d_we ? OpStore : OpLoad;
        end else if (f_issue) begin
            last_op_d = OpFetch;
        end
    end

    // Outputs decoded from last_op plus the combinational memory bus.
    always_comb begin
        bus.f_gnt    = f_issue || f_drop;
        bus.d_gnt    = d_issue || d_drop;
        bus.m_rw     = d_issue && bus.d_we;
        bus.m_data   = (d_issue && bus.d_we) ? bus.d_wdata : '0;
        bus.m_addr   = d_issue ? bus.d_addr : (f_issue ? bus.f_addr : m_addr_q);

        bus.f_rvalid = (last_op_q == OpFetch);
        bus.d_done   = (last_op_q == OpLoad) || (last_op_q == OpStore);
        // Read data passes straight through in the response cycle, then holds.
        bus.f_rdata  = (last_op_q == OpFetch) ? bus.m_q : f_rdata_q;
        bus.d_rdata  = (last_op_q == OpLoad) ? bus.m_q : d_rdata_q;

        stall        = (bus.d_req && !bus.d_gnt) || bus.d_done;
        err          = err_q;
        cnt_fetch    = cnt_fetch_q;
        cnt_data     = cnt_data_q;
        cnt_conflict = cnt_conflict_q;
    end

    // Datapath next-state: run counter, sticky error, held address/data, statistics.
    always_comb begin
        run_cnt_d      = run_cnt_q;
        err_d          = err_q || f_drop || d_drop;
        m_addr_d       = bus.m_addr;
        f_rdata_d      = bus.f_rdata;
        d_rdata_d      = bus.d_rdata;
        cnt_fetch_d    = f_issue ? sat_inc(cnt_fetch_q) : cnt_fetch_q;
        cnt_data_d     = d_issue ? sat_inc(cnt_data_q) : cnt_data_q;
        cnt_conflict_d = (d_issue && bus.f_req) ? sat_inc(cnt_conflict_q) : cnt_conflict_q;

        // Run length only matters while a fetch is actually waiting.
        if (!bus.f_req || bus.f_gnt) begin
            run_cnt_d = '0;
        end else if (d_issue && (run_cnt_q != {RUN_W{1'b1}})) begin
            run_cnt_d = run_cnt_q + {{(RUN_W-1){1'b0}}, 1'b1};
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt_q      <= '0;
            err_q          <= 1'b0;
            m_addr_q       <= '0;
            f_rdata_q      <= '0;
            d_rdata_q      <= '0;
            cnt_fetch_q    <= '0;
            cnt_data_q     <= '0;
            cnt_conflict_q <= '0;
        end else begin
            run_cnt_q      <= run_cnt_d;
            err_q          <= err_d;
            m_addr_q       <= m_addr_d;
            f_rdata_q      <= f_rdata_d;
            d_rdata_q      <= d_rdata_d;
            cnt_fetch_q    <= cnt_fetch_d;
            cnt_data_q     <= cnt_data_d;
            cnt_conflict_q <= cnt_conflict_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a scoreboard for read responses.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_load;
        logic [15:0] data;
    } d_exp_t;

    logic        clock;
    logic        reset_n;
    logic        stall, err, stall2, err2;
    logic [15:0] cnt_fetch, cnt_data, cnt_conflict;
    logic [15:0] cnt_fetch2, cnt_data2, cnt_conflict2;

    logic [15:0] mem [4096];
    logic [15:0] f_q [$];
    d_exp_t      d_q [$];
    logic [15:0] last_load;

    int errors;
    int checks;

    mem_port_arbiter_if #(.AW(12), .DW(16)) bus ();
    mem_port_arbiter_if #(.AW(12), .DW(16)) bus2 ();

    mem_port_arbiter #(
        .AW(12), .DW(16), .MAX_DATA_RUN(4), .ADDR_LIMIT(4095)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus.slave),
        .stall        (stall),
        .err          (err),
        .cnt_fetch    (cnt_fetch),
        .cnt_data     (cnt_data),
        .cnt_conflict (cnt_conflict)
    );

    mem_port_arbiter #(
        .AW(12), .DW(16), .MAX_DATA_RUN(4), .ADDR_LIMIT(255)
    ) dut_lim (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus2.slave),
        .stall        (stall2),
        .err          (err2),
        .cnt_fetch    (cnt_fetch2),
        .cnt_data     (cnt_data2),
        .cnt_conflict (cnt_conflict2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memory model: write on m_rw, registered read data.
    always @(posedge clock) begin
        if (bus.m_rw === 1'b1) mem[bus.m_addr] <= bus.m_data;
        bus.m_q <= mem[bus.m_addr];
    end

    task automatic monitor();
        d_exp_t e;
        logic [15:0] fe;
        forever begin
            @(negedge clock);
            if (bus.f_rvalid === 1'b1) begin
                checks++;
                if (f_q.size() == 0) begin
                    errors++;
                    $display("FAIL f_rvalid_unexpected: f_rdata=%h, required no response", bus.f_rdata);
                end else begin
                    fe = f_q.pop_front();
                    if (bus.f_rdata !== fe) begin
                        errors++;
                        $display("FAIL f_rdata: got %h, required %h", bus.f_rdata, fe);
                    end
                end
            end
            if (bus.d_done === 1'b1) begin
                checks++;
                if (d_q.size() == 0) begin
                    errors++;
                    $display("FAIL d_done_unexpected: d_rdata=%h, required no response", bus.d_rdata);
                end else begin
                    e = d_q.pop_front();
                    if (bus.d_rdata !== e.data) begin
                        errors++;
                        $display("FAIL d_rdata(load=%0b): got %h, required %h", e.is_load, bus.d_rdata, e.data);
                    end
                end
            end
            if (bus2.f_rvalid !== 1'b0 || bus2.d_done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL lim_response: f_rvalid=%b d_done=%b, required 0 0", bus2.f_rvalid, bus2.d_done);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.f_req = 1'b0; bus.f_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0;
        bus2.f_req = 1'b0; bus2.f_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
        bus2.d_addr = '0; bus2.d_wdata = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        bus2.m_q = '0;
        // Requests during reset must not leak onto the bus.
        bus.f_req = 1'b1; bus.f_addr = 12'h004;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h010; bus.d_wdata = 16'h5555;
        @(negedge clock);
        checks++;
        if (bus.f_gnt !== 1'b0 || bus.d_gnt !== 1'b0 || bus.m_rw !== 1'b0 || bus.m_addr !== 12'h0) begin
            errors++;
            $display("FAIL reset_gating: f_gnt=%b d_gnt=%b m_rw=%b m_addr=%h, required 0 0 0 000",
                     bus.f_gnt, bus.d_gnt, bus.m_rw, bus.m_addr);
        end
        checks++;
        if (bus.f_rvalid !== 1'b0 || bus.d_done !== 1'b0 || bus.f_rdata !== 16'h0 ||
            bus.d_rdata !== 16'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: f_rvalid=%b d_done=%b f_rdata=%h d_rdata=%h err=%b, required all 0",
                     bus.f_rvalid, bus.d_done, bus.f_rdata, bus.d_rdata, err);
        end
        checks++;
        if (cnt_fetch !== 16'h0 || cnt_data !== 16'h0 || cnt_conflict !== 16'h0) begin
            errors++;
            $display("FAIL reset_counters: %h %h %h, required 0 0 0", cnt_fetch, cnt_data, cnt_conflict);
        end
        idle_inputs();
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_fetch_stream();
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            bus.f_req = 1'b1; bus.f_addr = 12'(i);
            @(negedge clock);
            checks++;
            if (bus.f_gnt !== 1'b1 || bus.m_addr !== 12'(i) || stall !== 1'b0 || bus.m_rw !== 1'b0) begin
                errors++;
                $display("FAIL fetch_gnt[%0d]: f_gnt=%b m_addr=%h stall=%b m_rw=%b, required 1 %h 0 0",
                         i, bus.f_gnt, bus.m_addr, stall, bus.m_rw, 12'(i));
            end
            f_q.push_back(16'hA000 + 16'(i));
            if (i > 0) begin
                checks++;
                if (bus.f_rvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL fetch_rvalid[%0d]: got %b, required 1", i, bus.f_rvalid);
                end
            end
            @(posedge clock); #1;
        end
        bus.f_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (bus.m_addr !== 12'h003 || bus.f_rdata !== 16'hA003 || f_q.size() != 0) begin
            errors++;
            $display("FAIL fetch_hold: m_addr=%h f_rdata=%h pending=%0d, required 003 a003 0",
                     bus.m_addr, bus.f_rdata, f_q.size());
        end
    endtask

    task automatic test_conflict();
        @(posedge clock); #1;
        bus.f_req = 1'b1; bus.f_addr = 12'h005;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h100;
        @(negedge clock);
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.f_gnt !== 1'b0 || bus.m_addr !== 12'h100 || stall !== 1'b0) begin
            errors++;
            $display("FAIL conflict_first: d_gnt=%b f_gnt=%b m_addr=%h stall=%b, required 1 0 100 0",
                     bus.d_gnt, bus.f_gnt, bus.m_addr, stall);
        end
        d_q.push_back('{is_load: 1'b1, data: 16'h1234});
        last_load = 16'h1234;
        @(posedge clock); #1;
        bus.d_req = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.f_gnt !== 1'b1 || bus.m_addr !== 12'h005 || stall !== 1'b1) begin
            errors++;
            $display("FAIL conflict_second: f_gnt=%b m_addr=%h stall=%b, required 1 005 1",
                     bus.f_gnt, bus.m_addr, stall);
        end
        f_q.push_back(16'hA005);
        @(posedge clock); #1;
        bus.f_req = 1'b0;
        @(negedge clock);
        checks++;
        if (cnt_conflict !== 16'd1 || cnt_fetch !== 16'd5 || cnt_data !== 16'd1) begin
            errors++;
            $display("FAIL conflict_counters: conflict=%0d fetch=%0d data=%0d, required 1 5 1",
                     cnt_conflict, cnt_fetch, cnt_data);
        end
    endtask

    task automatic test_store_load();
        @(posedge clock); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h200; bus.d_wdata = 16'hBEEF;
        @(negedge clock);
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.m_rw !== 1'b1 || bus.m_data !== 16'hBEEF || bus.m_addr !== 12'h200) begin
            errors++;
            $display("FAIL store_bus: d_gnt=%b m_rw=%b m_data=%h m_addr=%h, required 1 1 beef 200",
                     bus.d_gnt, bus.m_rw, bus.m_data, bus.m_addr);
        end
        d_q.push_back('{is_load: 1'b0, data: last_load});
        @(posedge clock); #1;
        bus.d_we = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.m_rw !== 1'b0 || bus.d_done !== 1'b1) begin
            errors++;
            $display("FAIL load_bus: d_gnt=%b m_rw=%b d_done=%b, required 1 0 1", bus.d_gnt, bus.m_rw, bus.d_done);
        end
        d_q.push_back('{is_load: 1'b1, data: 16'hBEEF});
        last_load = 16'hBEEF;
        @(posedge clock); #1;
        bus.d_req = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.m_rw !== 1'b0 || bus.d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL store_once: m_rw=%b d_gnt=%b, required 0 0", bus.m_rw, bus.d_gnt);
        end
    endtask

    task automatic test_starvation();
        bit pat [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int ld = 0;
        bit fetched = 1'b0;
        @(posedge clock); #1;
        for (int k = 0; k < 7; k++) begin
            bus.d_req = (ld < 6); bus.d_we = 1'b0; bus.d_addr = 12'h101 + 12'(ld);
            bus.f_req = !fetched; bus.f_addr = 12'h006;
            @(negedge clock);
            checks++;
            if (bus.d_gnt !== pat[k] || bus.f_gnt !== !pat[k]) begin
                errors++;
                $display("FAIL starve_grant[%0d]: d_gnt=%b f_gnt=%b, required %b %b",
                         k, bus.d_gnt, bus.f_gnt, pat[k], !pat[k]);
            end
            if (k > 0 && !pat[k-1]) begin
                checks++;
                if (dut.run_cnt_q !== 4'd0) begin
                    errors++;
                    $display("FAIL starve_run_clear: run_cnt=%0d, required 0", dut.run_cnt_q);
                end
            end
            if (pat[k]) begin
                d_q.push_back('{is_load: 1'b1, data: 16'hA101 + 16'(ld)});
                last_load = 16'hA101 + 16'(ld);
                ld++;
            end else begin
                f_q.push_back(16'hA006);
                fetched = 1'b1;
            end
            @(posedge clock); #1;
        end
        bus.d_req = 1'b0; bus.f_req = 1'b0;
        @(negedge clock);
        checks++;
        if (cnt_conflict !== 16'd5 || d_q.size() != 0 || f_q.size() != 0) begin
            errors++;
            $display("FAIL starve_end: conflict=%0d pending_d=%0d pending_f=%0d, required 5 0 0",
                     cnt_conflict, d_q.size(), f_q.size());
        end
    endtask

    task automatic test_out_of_range();
        @(posedge clock); #1;
        bus2.d_req = 1'b1; bus2.d_we = 1'b1; bus2.d_addr = 12'h100; bus2.d_wdata = 16'hDEAD;
        @(negedge clock);
        checks++;
        if (bus2.m_rw !== 1'b0 || bus2.d_gnt !== 1'b1 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL oor_drop: m_rw=%b d_gnt=%b err=%b, required 0 1 0", bus2.m_rw, bus2.d_gnt, err2);
        end
        @(posedge clock); #1;
        bus2.d_req = 1'b0;
        @(negedge clock);
        checks++;
        if (err2 !== 1'b1 || cnt_data2 !== 16'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL oor_err: err=%b cnt_data=%0d main_err=%b, required 1 0 0", err2, cnt_data2, err);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (err2 !== 1'b1) begin
            errors++;
            $display("FAIL oor_sticky: err=%b, required 1", err2);
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clock); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h100;
        @(negedge clock);
        checks++;
        if (bus.d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant: d_gnt=%b, required 1", bus.d_gnt);
        end
        @(posedge clock); #1;
        reset_n = 1'b0;
        bus.d_we = 1'b1; bus.d_addr = 12'h300; bus.d_wdata = 16'hFFFF;
        bus.f_req = 1'b1; bus.f_addr = 12'h007;
        @(negedge clock);
        checks++;
        if (bus.d_done !== 1'b0 || bus.m_rw !== 1'b0 || bus.d_gnt !== 1'b0 || bus.f_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: d_done=%b m_rw=%b d_gnt=%b f_gnt=%b, required 0 0 0 0",
                     bus.d_done, bus.m_rw, bus.d_gnt, bus.f_gnt);
        end
        checks++;
        if (cnt_fetch !== 16'h0 || cnt_data !== 16'h0 || cnt_conflict !== 16'h0 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: %h %h %h err=%b, required 0 0 0 0",
                     cnt_fetch, cnt_data, cnt_conflict, err2);
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.f_gnt !== 1'b1 || bus.m_addr !== 12'h007) begin
            errors++;
            $display("FAIL post_reset_grant: f_gnt=%b m_addr=%h, required 1 007", bus.f_gnt, bus.m_addr);
        end
        f_q.push_back(16'hA007);
        @(posedge clock); #1;
        bus.f_req = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (f_q.size() != 0 || d_q.size() != 0 || cnt_fetch !== 16'd1) begin
            errors++;
            $display("FAIL final_drain: pending_f=%0d pending_d=%0d cnt_fetch=%0d, required 0 0 1",
                     f_q.size(), d_q.size(), cnt_fetch);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        last_load = 16'h0;
        for (int a = 0; a < 4096; a++) mem[a] = 16'hA000 + 16'(a);
        mem[12'h100] = 16'h1234;
        test_reset();
        fork
            monitor();
        join_none
        test_fetch_stream();
        test_conflict();
        test_store_load();
        test_starvation();
        test_out_of_range();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
